// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_e     debounce FSM states
//   frame_e     per-frame classification of the scanned matrix
//   KEY_TABLE   16-entry key layout, entry (row*4 + col) in bits [idx*4 +: 4]
//   KEY_CLR / KEY_BS / KEY_ENT  codes of the editing keys
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HELD      = 2'd2,
      REL_CHK   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      FR_NONE   = 2'd0,
      FR_SINGLE = 2'd1,
      FR_MULTI  = 2'd2
   } frame_e;

   // Rows from top: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D (lowest nibble = row0,col0).
   localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

   localparam logic [3:0] KEY_CLR = 4'hA;
   localparam logic [3:0] KEY_BS  = 4'hB;
   localparam logic [3:0] KEY_ENT = 4'hF;

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      logic [5:0] base;
      base = {row, col, 2'b00};
      return KEY_TABLE[base +: 4];
   endfunction

endpackage

// File: rtl/keypad_entry.sv
// keypad_entry: decimal entry accumulator driven by accepted keys.
//   CLK, reset    clock, asynchronous active-low reset
//   key_valid     strobe of an accepted key (same cycle as the code below)
//   key_code      code of the accepted key
//   entry_value   value of up to four decimal digits, 0..9999
//   entry_done    one-cycle pulse when the enter key is accepted
module keypad_entry
   import keypad_pkg::*;
(
   input  logic        CLK,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [13:0] entry_value,
   output logic        entry_done
);

   logic [13:0] value_q, value_d;
   logic [2:0]  digits_q, digits_d;
   logic        done_q, done_d;
   logic [13:0] base_s;

   // Next value / digit count from the accepted key.
   always_comb begin
      value_d  = value_q;
      digits_d = digits_q;
      done_d   = 1'b0;
      // A digit count of zero means a fresh entry, so the old value is discarded.
      if (digits_q == 3'd0) begin
         base_s = 14'd0;
      end else begin
         base_s = value_q;
      end
      if (key_valid) begin
         if (key_code <= 4'd9) begin
            if (digits_q < 3'd4) begin
               value_d  = base_s * 14'd10 + {10'd0, key_code};
               digits_d = digits_q + 3'd1;
            end else begin
               value_d  = value_q;
            end
         end else begin
            case (key_code)
               KEY_CLR: begin
                  value_d  = 14'd0;
                  digits_d = 3'd0;
               end
               KEY_BS: begin
                  if (digits_q != 3'd0) begin
                     value_d  = value_q / 14'd10;
                     digits_d = digits_q - 3'd1;
                  end else begin
                     value_d  = value_q;
                  end
               end
               KEY_ENT: begin
                  done_d   = 1'b1;
                  digits_d = 3'd0;
               end
               default: begin
                  value_d  = value_q;
               end
            endcase
         end
      end else begin
         done_d = 1'b0;
      end
   end

   // Accumulator registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         value_q  <= 14'd0;
         digits_q <= 3'd0;
         done_q   <= 1'b0;
      end else begin
         value_q  <= value_d;
         digits_q <= digits_d;
         done_q   <= done_d;
      end
   end

   assign entry_value = value_q;
   assign entry_done  = done_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and decimal entry.
//   CLK          system clock
//   reset        asynchronous active-low reset
//   col_n[3:0]   active-low column drive, one column low at a time
//   row_n[3:0]   active-low row sense (asynchronous, pulled up)
//   key_valid    one-cycle pulse per accepted key press
//   key_code     last accepted key code, held between pulses
//   entry_value  decimal entry value 0..9999
//   entry_done   one-cycle pulse when the enter key is accepted
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic        CLK,
   input  logic        reset,
   output logic [3:0]  col_n,
   input  logic [3:0]  row_n,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [13:0] entry_value,
   output logic        entry_done
);

   localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [7:0]     DB_MAX   = 8'(DEBOUNCE_CNT);

   logic [3:0]       row_s1_q, row_s2_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_n_q, col_n_d;
   logic [1:0]       acc_cnt_q, acc_cnt_d;
   logic [3:0]       acc_code_q, acc_code_d;
   state_e           state_q, state_d;
   logic [7:0]       stab_q, stab_d;
   logic [3:0]       cand_q, cand_d;
   logic             armed_q, armed_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       key_code_q, key_code_d;

   logic             sample_s, frame_end_s, accept_s;
   logic [3:0]       hits_s;
   logic [2:0]       hit_cnt_s, sum_s;
   logic [1:0]       hit_row_s, frame_cnt_s;
   logic [3:0]       frame_code_s;
   logic [7:0]       stab_inc_s;
   frame_e           frame_class_s;

   // Two-flop synchronizer on the asynchronous row inputs.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         row_s1_q <= 4'hF;
         row_s2_q <= 4'hF;
      end else begin
         row_s1_q <= row_n;
         row_s2_q <= row_s1_q;
      end
   end

   // Column sample: count keys seen in this column and merge into the frame.
   always_comb begin
      sample_s    = (div_q == DIV_LAST);
      frame_end_s = sample_s && (col_idx_q == 2'd3);
      hits_s      = ~row_s2_q;
      hit_cnt_s   = 3'd0;
      hit_row_s   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         hit_cnt_s = hit_cnt_s + {2'b00, hits_s[i]};
         if (hits_s[i]) begin
            hit_row_s = 2'(i);
         end else begin
            hit_row_s = hit_row_s;
         end
      end
      // Key count saturates at 2: anything beyond one key is simply MULTI.
      sum_s = {1'b0, acc_cnt_q} + hit_cnt_s;
      if (sum_s >= 3'd2) begin
         frame_cnt_s = 2'd2;
      end else begin
         frame_cnt_s = sum_s[1:0];
      end
      if ((acc_cnt_q == 2'd0) && (hit_cnt_s == 3'd1)) begin
         frame_code_s = key_lookup(hit_row_s, col_idx_q);
      end else begin
         frame_code_s = acc_code_q;
      end
      case (frame_cnt_s)
         2'd0:    frame_class_s = FR_NONE;
         2'd1:    frame_class_s = FR_SINGLE;
         default: frame_class_s = FR_MULTI;
      endcase
   end

   // Scan divider, column rotation and frame accumulator next state.
   always_comb begin
      div_d      = div_q;
      col_idx_d  = col_idx_q;
      col_n_d    = col_n_q;
      acc_cnt_d  = acc_cnt_q;
      acc_code_d = acc_code_q;
      if (sample_s) begin
         div_d     = {DIV_W{1'b0}};
         col_idx_d = col_idx_q + 2'd1;
         col_n_d   = {col_n_q[2:0], col_n_q[3]};
         if (frame_end_s) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = 4'd0;
         end else begin
            acc_cnt_d  = frame_cnt_s;
            acc_code_d = frame_code_s;
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Debounce FSM: evaluated once per frame.
   always_comb begin
      state_d     = state_q;
      stab_d      = stab_q;
      cand_d      = cand_q;
      armed_d     = armed_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      accept_s    = 1'b0;
      stab_inc_s  = stab_q + 8'd1;
      if (frame_end_s) begin
         case (state_q)
            IDLE: begin
               // A key already down when reset ends must be released before it can count.
               if (frame_class_s == FR_NONE) begin
                  armed_d = 1'b1;
               end else begin
                  armed_d = armed_q;
               end
               if (armed_q && (frame_class_s == FR_SINGLE)) begin
                  cand_d = frame_code_s;
                  if (DB_MAX <= 8'd1) begin
                     accept_s = 1'b1;
                  end else begin
                     state_d = PRESS_CHK;
                     stab_d  = 8'd1;
                  end
               end else begin
                  state_d = IDLE;
                  stab_d  = 8'd0;
               end
            end
            PRESS_CHK: begin
               if ((frame_class_s == FR_SINGLE) && (frame_code_s == cand_q)) begin
                  if (stab_inc_s >= DB_MAX) begin
                     accept_s = 1'b1;
                  end else begin
                     stab_d = stab_inc_s;
                  end
               end else begin
                  state_d = IDLE;
                  stab_d  = 8'd0;
               end
            end
            HELD: begin
               if (frame_class_s == FR_NONE) begin
                  if (DB_MAX <= 8'd1) begin
                     state_d = IDLE;
                     stab_d  = 8'd0;
                  end else begin
                     state_d = REL_CHK;
                     stab_d  = 8'd1;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            REL_CHK: begin
               if (frame_class_s == FR_NONE) begin
                  if (stab_inc_s >= DB_MAX) begin
                     state_d = IDLE;
                     stab_d  = 8'd0;
                  end else begin
                     stab_d  = stab_inc_s;
                  end
               end else begin
                  state_d = HELD;
                  stab_d  = 8'd0;
               end
            end
            default: begin
               state_d = IDLE;
               stab_d  = 8'd0;
            end
         endcase
         if (accept_s) begin
            key_valid_d = 1'b1;
            key_code_d  = cand_d;
            state_d     = HELD;
            stab_d      = 8'd0;
         end else begin
            key_valid_d = 1'b0;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Scan, accumulator and FSM registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         div_q       <= {DIV_W{1'b0}};
         col_idx_q   <= 2'd0;
         col_n_q     <= 4'b1110;
         acc_cnt_q   <= 2'd0;
         acc_code_q  <= 4'd0;
         state_q     <= IDLE;
         stab_q      <= 8'd0;
         cand_q      <= 4'd0;
         armed_q     <= 1'b0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
      end else begin
         div_q       <= div_d;
         col_idx_q   <= col_idx_d;
         col_n_q     <= col_n_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_code_q  <= acc_code_d;
         state_q     <= state_d;
         stab_q      <= stab_d;
         cand_q      <= cand_d;
         armed_q     <= armed_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

   // Fed with the next-state strobe so entry outputs change together with key_valid.
   keypad_entry u_entry (
      .CLK         (CLK),
      .reset       (reset),
      .key_valid   (key_valid_d),
      .key_code    (key_code_d),
      .entry_value (entry_value),
      .entry_done  (entry_done)
   );

   assign col_n     = col_n_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;

endmodule
